// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched
// Command scheduler in front of the calculator core's cmd input. Two
// requesters (A: keypad decoder, B: script/self-test player) are
// round-robin arbitrated into a shared FIFO. Commands are then issued to
// the core one at a time, each paced by the core's 2-bit status. A core
// error or a stuck-busy timeout traps the scheduler in ERR and flushes the
// queue until err_clr is pulsed.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   req_a/cmd_a  in   source A request and 4-bit command
//   ack_a        out  source A command accepted this cycle (combinational)
//   req_b/cmd_b  in   source B request and 4-bit command
//   ack_b        out  source B command accepted this cycle (combinational)
//   calc_status  in   00 idle, 01 busy, 10 error, 11 reserved (busy)
//   calc_cmd     out  registered command, one-cycle pulse per command,
//                     NOP_CMD otherwise
//   fifo_count   out  registered FIFO occupancy
//   sched_busy   out  FSM not in IDLE or FIFO not empty
//   err_flag     out  sticky error indication
//   err_timeout  out  qualifies err_flag: 1 = timeout, 0 = core error
//   err_clr      in   one-cycle pulse that releases ERR
//   dbg_state    out  current FSM state (0 IDLE, 1 WAIT, 2 ERR)
//
// Handshake: a requester raises req_x with a stable cmd_x and holds both
// until it sees ack_x high. The command is written into the FIFO at the
// rising edge that ends the cycle in which ack_x is high; ack_x depends
// combinationally on req_a/req_b and registered state only.

module calc_cmd_sched #(
  parameter int         DEPTH    = 8,
  parameter logic [3:0] NOP_CMD  = 4'hF,
  parameter int         MIN_WAIT = 2,
  parameter int         TIMEOUT  = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_a,
  input  logic [3:0]               cmd_a,
  output logic                     ack_a,
  input  logic                     req_b,
  input  logic [3:0]               cmd_b,
  output logic                     ack_b,
  input  logic [1:0]               calc_status,
  output logic [3:0]               calc_cmd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sched_busy,
  output logic                     err_flag,
  output logic                     err_timeout,
  input  logic                     err_clr,
  output logic [1:0]               dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] wait_inc;
  logic [3:0]    calc_cmd_q, calc_cmd_d;
  logic          ptr_b_q, ptr_b_d;      // 1: B wins the next contested grant
  logic          err_flag_q, err_flag_d;
  logic          err_timeout_q, err_timeout_d;

  logic          push_ok;
  logic          push;
  logic          pop;
  logic [3:0]    push_data;

  // Arbitration and FIFO control. Full is judged on the registered count,
  // so a push is refused when full even if a pop happens in the same cycle.
  always_comb begin
    push_ok   = (state_q != ST_ERR) && (count_q < CW'(DEPTH));
    ack_a     = push_ok & req_a & (~req_b | ~ptr_b_q);
    ack_b     = push_ok & req_b & (~req_a | ptr_b_q);
    push      = ack_a | ack_b;
    push_data = ack_a ? cmd_a : cmd_b;
    pop       = (state_q == ST_IDLE) && (count_q != '0) && (calc_status == 2'b00);
  end

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wait_inc      = wait_cnt_q + 1'b1;
    wait_cnt_d    = wait_cnt_q;
    calc_cmd_d    = NOP_CMD;
    ptr_b_d       = ptr_b_q;
    err_flag_d    = err_flag_q;
    err_timeout_d = err_timeout_q;

    // Only a contested grant moves the pointer, and it moves to the loser.
    if (push && req_a && req_b) begin
      ptr_b_d = ack_a;
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          calc_cmd_d = mem_q[rd_ptr_q];
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_inc;
        if (calc_status == 2'b10) begin
          state_d       = ST_ERR;
          err_flag_d    = 1'b1;
          err_timeout_d = 1'b0;
        end else if (wait_inc == TW'(TIMEOUT)) begin
          // The counter reaches TIMEOUT at this edge: TIMEOUT cycles in WAIT.
          state_d       = ST_ERR;
          err_flag_d    = 1'b1;
          err_timeout_d = 1'b1;
        end else if ((wait_cnt_q >= TW'(MIN_WAIT - 1)) && (calc_status == 2'b00)) begin
          state_d = ST_IDLE;
        end

        // Entering ERR flushes the queue; this wins over a same-cycle push.
        if (state_d == ST_ERR) begin
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end

      ST_ERR: begin
        if (err_clr) begin
          state_d       = ST_IDLE;
          err_flag_d    = 1'b0;
          err_timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_cnt_q    <= '0;
      calc_cmd_q    <= NOP_CMD;
      ptr_b_q       <= 1'b0;
      err_flag_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_cnt_q    <= wait_cnt_d;
      calc_cmd_q    <= calc_cmd_d;
      ptr_b_q       <= ptr_b_d;
      err_flag_q    <= err_flag_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign calc_cmd    = calc_cmd_q;
  assign fifo_count  = count_q;
  assign sched_busy  = (state_q != ST_IDLE) || (count_q != '0);
  assign err_flag    = err_flag_q;
  assign err_timeout = err_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched. Commands are pushed into exp_q when
// the bench expects them to be issued; a negedge monitor pops and compares
// every non-NOP value seen on calc_cmd.

module tb_calc_cmd_sched;

  localparam int         DEPTH    = 8;
  localparam logic [3:0] NOP_CMD  = 4'hF;
  localparam int         MIN_WAIT = 2;
  localparam int         TIMEOUT  = 5;
  localparam int         CW       = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a;
  logic [3:0]    cmd_a;
  logic          ack_a;
  logic          req_b;
  logic [3:0]    cmd_b;
  logic          ack_b;
  logic [1:0]    calc_status;
  logic [3:0]    calc_cmd;
  logic [CW-1:0] fifo_count;
  logic          sched_busy;
  logic          err_flag;
  logic          err_timeout;
  logic          err_clr;
  logic [1:0]    dbg_state;

  logic [3:0] exp_q[$];
  int         issue_cyc_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;

  calc_cmd_sched #(
    .DEPTH    (DEPTH),
    .NOP_CMD  (NOP_CMD),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_a       (req_a),
    .cmd_a       (cmd_a),
    .ack_a       (ack_a),
    .req_b       (req_b),
    .cmd_b       (cmd_b),
    .ack_b       (ack_b),
    .calc_status (calc_status),
    .calc_cmd    (calc_cmd),
    .fifo_count  (fifo_count),
    .sched_busy  (sched_busy),
    .err_flag    (err_flag),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .dbg_state   (dbg_state)
  );

  // Clock / cycle count
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive A for one cycle starting after the next edge; req_a stays high
  // on return so back-to-back calls keep the request continuous.
  task automatic push_a(input logic [3:0] c, input bit exp_ack, input bit track);
    tick();
    req_a = 1'b1;
    cmd_a = c;
    @(negedge clock);
    chk("push_ack_a", ack_a, exp_ack);
    if (track) exp_q.push_back(c);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sched_busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("idle_busy", sched_busy, 0);
    chk("idle_pending", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en && calc_cmd !== NOP_CMD) begin
      issue_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("issue_spurious", calc_cmd, NOP_CMD);
      else                   chk("issue_order", calc_cmd, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; req_a = 1'b0; cmd_a = '0; req_b = 1'b0; cmd_b = '0;
    calc_status = 2'b00; err_clr = 1'b0;

    // ---- reset and single command
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_calc_cmd", calc_cmd, NOP_CMD);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_state", dbg_state, 0);
    mon_en = 1'b1;

    push_a(4'h3, 1'b1, 1'b1);
    tick(); req_a = 1'b0;
    @(negedge clock);
    chk("single_count_n", fifo_count, 1);
    chk("single_cmd_n", calc_cmd, NOP_CMD);
    tick();
    @(negedge clock);
    chk("single_cmd_n1", calc_cmd, 4'h3);
    chk("single_count_n1", fifo_count, 0);
    chk("single_busy_n1", sched_busy, 1);
    tick();
    @(negedge clock);
    chk("single_cmd_n2", calc_cmd, NOP_CMD);
    wait_idle(20);

    // ---- command equal to NOP_CMD is queued and issued
    push_a(NOP_CMD, 1'b1, 1'b0);
    tick(); req_a = 1'b0;
    @(negedge clock);
    chk("nopval_count", fifo_count, 1);
    tick();
    @(negedge clock);
    chk("nopval_state", dbg_state, 1);
    chk("nopval_count_after", fifo_count, 0);
    wait_idle(20);

    // ---- contention and fairness
    tick();
    req_a = 1'b1; req_b = 1'b1; cmd_a = 4'h1; cmd_b = 4'h2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("contend_ack_a", ack_a, (i % 2 == 0));
      chk("contend_ack_b", ack_b, (i % 2 == 1));
      exp_q.push_back((i % 2 == 0) ? 4'h1 : 4'h2);
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle(40);

    // ---- full FIFO, then drain
    calc_status = 2'b01;
    for (int i = 0; i < 9; i++) begin
      push_a(4'(i), (i < 8), (i < 8));
      chk("full_count", fifo_count, i);
    end
    tick(); req_a = 1'b0;
    @(negedge clock);
    chk("full_count_final", fifo_count, 8);
    chk("full_busy", sched_busy, 1);
    issue_cyc_q.delete();
    calc_status = 2'b00;
    wait_idle(60);
    chk("drain_n", issue_cyc_q.size(), 8);
    for (int i = 1; i < issue_cyc_q.size(); i++) begin
      chk("drain_gap", issue_cyc_q[i] - issue_cyc_q[i-1], MIN_WAIT + 1);
    end

    // ---- core error during first WAIT
    calc_status = 2'b01;
    push_a(4'h5, 1'b1, 1'b1);
    push_a(4'h6, 1'b1, 1'b0);
    push_a(4'h7, 1'b1, 1'b0);
    tick(); req_a = 1'b0; calc_status = 2'b00;
    tick(); calc_status = 2'b10;
    tick(); req_a = 1'b1; req_b = 1'b1; cmd_a = 4'h1; cmd_b = 4'h2;
    @(negedge clock);
    chk("cerr_flag", err_flag, 1);
    chk("cerr_timeout", err_timeout, 0);
    chk("cerr_count", fifo_count, 0);
    chk("cerr_ack_a", ack_a, 0);
    chk("cerr_ack_b", ack_b, 0);
    chk("cerr_busy", sched_busy, 1);
    tick(); req_a = 1'b0; req_b = 1'b0; err_clr = 1'b1; calc_status = 2'b00;
    @(negedge clock);
    chk("cerr_flag_hold", err_flag, 1);
    tick(); err_clr = 1'b0;
    @(negedge clock);
    chk("cerr_clr_flag", err_flag, 0);
    chk("cerr_clr_state", dbg_state, 0);
    chk("cerr_clr_busy", sched_busy, 0);
    wait_idle(10);

    // ---- timeout with core stuck busy
    push_a(4'h9, 1'b1, 1'b1);
    tick(); req_a = 1'b0;
    tick(); calc_status = 2'b01;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clock);
      chk("to_pending", err_flag, 0);
      tick();
    end
    @(negedge clock);
    chk("to_flag", err_flag, 1);
    chk("to_timeout", err_timeout, 1);
    chk("to_state", dbg_state, 2);
    tick(); err_clr = 1'b1; calc_status = 2'b00;
    tick(); err_clr = 1'b0;
    @(negedge clock);
    chk("to_clr_flag", err_flag, 0);
    chk("to_clr_timeout", err_timeout, 0);
    wait_idle(10);

    // ---- reset mid-WAIT with 4 commands still queued
    calc_status = 2'b01;
    push_a(4'hA, 1'b1, 1'b1);
    push_a(4'hB, 1'b1, 1'b0);
    push_a(4'hC, 1'b1, 1'b0);
    push_a(4'hD, 1'b1, 1'b0);
    push_a(4'hE, 1'b1, 1'b0);
    tick(); req_a = 1'b0; calc_status = 2'b00;
    tick(); calc_status = 2'b01;
    @(negedge clock);
    chk("rmid_count", fifo_count, 4);
    chk("rmid_state", dbg_state, 1);
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clock);
    chk("rmid_calc_cmd", calc_cmd, NOP_CMD);
    chk("rmid_count_after", fifo_count, 0);
    chk("rmid_busy", sched_busy, 0);
    calc_status = 2'b00;
    repeat (10) @(negedge clock);
    chk("rmid_pending", exp_q.size(), 0);
    chk("rmid_idle_count", fifo_count, 0);
    chk("rmid_idle_busy", sched_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
